// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Slow data-memory model for the pipeline's memory port. Accepts
//            one load/store at a time over a valid/ready request channel,
//            waits LATENCY cycles, performs the access on an internal
//            word-addressed array and returns a held response over a
//            valid/ready response channel.
// Ports    : clk_i        rising-edge clock
//            rst_ni       asynchronous active-low reset
//            req_valid_i  request present
//            req_ready_o  block can accept a request this cycle (registered)
//            req_we_i     1 = store, 0 = load
//            req_addr_i   byte address
//            req_wdata_i  store data
//            req_wstrb_i  store byte enables, bit i -> bits [8i+7:8i]
//            rsp_valid_o  response present (registered)
//            rsp_ready_i  core accepts response
//            rsp_rdata_o  load data, 0 for stores and errors (registered)
//            rsp_err_o    misaligned or out-of-range request (registered)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,  // power of two, >= 4
  parameter int LATENCY     = 2      // 0..15 wait states
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          addr_err;
  logic [AW-1:0] word_idx;
  logic          do_access;

  // Word index beyond the array, or any low address bit set, is an error.
  assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
  assign word_idx  = addr_q[AW+1:2];
  // Access happens on the WAIT->RESP edge. Reset forces state_q to IDLE
  // immediately, so an abandoned request can never write.
  assign do_access = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  always_ff @(posedge clk_i) begin
    if (do_access && we_q && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem_q[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Ready rises one edge after reset release; a request is only
          // taken on an edge where ready was already visible.
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            wstrb_q     <= req_wstrb_i;
            cnt_q       <= 4'(LATENCY);
            req_ready_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= addr_err;
            rsp_rdata_q <= (addr_err || we_q) ? 32'd0 : mem_q[word_idx];
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder (LATENCY = 2,
//            DEPTH_WORDS = 1024). Inputs are driven on the falling edge and
//            outputs sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int LAT     = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int passes = 0;
  int total  = 0;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Full transaction: wait for ready, accept, scramble inputs, measure
  // latency, optionally hold backpressure for bp cycles, then handshake.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input int bp,
                      output logic [31:0] rd, output logic er);
    int   n;
    logic rdy_seen;
    logic [31:0] held;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    rsp_ready = (bp == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept_timeout"}, 32'(n < 20), 32'd1);
    @(posedge clk);  // accept edge E0
    @(negedge clk);
    // Later input changes must not affect the captured request.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'h0000_0020;
    req_wdata = $urandom;
    req_wstrb = 4'hF;
    n = 0;
    rdy_seen = 1'b0;
    while (!rsp_valid && n < 30) begin
      rdy_seen |= req_ready;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(LAT + 1));
    chk({tag, "_ready_low_wait"}, {31'd0, rdy_seen | req_ready}, 32'd0);
    rd = rsp_rdata;
    er = rsp_err;
    if (bp > 0) begin
      held = rsp_rdata;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk({tag, "_bp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_bp_rdata"}, rsp_rdata, held);
        chk({tag, "_bp_ready"}, {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);  // response handshake
    @(negedge clk);
    chk({tag, "_post_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_post_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_post_rdata"}, rsp_rdata, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0000;
    req_wdata = 32'hFFFF_FFFF;
    req_wstrb = 4'hF;
    rsp_ready = 1'b1;

    // Reset held 3 cycles with req_valid high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    // Ready still high means nothing was accepted on the release edge.
    chk("rel_no_accept", {31'd0, req_ready}, 32'd1);

    // Store then load.
    xfer("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    chk("st10_rdata", rd, 32'd0);
    chk("st10_err", {31'd0, er}, 32'd0);
    xfer("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    chk("ld10_rdata", rd, 32'hDEAD_BEEF);
    chk("ld10_err", {31'd0, er}, 32'd0);

    // Byte strobes.
    xfer("st20a", 1'b1, 32'h20, 32'hAAAA_AAAA, 4'hF, 0, rd, er);
    xfer("st20b", 1'b1, 32'h20, 32'h1122_3344, 4'b0101, 0, rd, er);
    xfer("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    chk("ld20_rdata", rd, 32'hAA22_AA44);

    // Zero strobe: response produced, array unchanged.
    xfer("st20z", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, rd, er);
    chk("st20z_err", {31'd0, er}, 32'd0);
    xfer("ld20z", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    chk("ld20z_rdata", rd, 32'hAA22_AA44);

    // Errors.
    xfer("st00", 1'b1, 32'h0, 32'h0123_4567, 4'hF, 0, rd, er);
    xfer("ld13", 1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er);
    chk("ld13_err", {31'd0, er}, 32'd1);
    chk("ld13_rdata", rd, 32'd0);
    xfer("st_oor", 1'b1, 32'(4 * DEPTH), 32'hCAFE_F00D, 4'hF, 0, rd, er);
    chk("st_oor_err", {31'd0, er}, 32'd1);
    chk("st_oor_rdata", rd, 32'd0);
    xfer("ld00", 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
    chk("ld00_rdata", rd, 32'h0123_4567);
    xfer("ld_last", 1'b0, 32'(4 * DEPTH - 4), 32'h0, 4'h0, 0, rd, er);
    chk("ld_last_err", {31'd0, er}, 32'd0);

    // Backpressure: 5 cycles with rsp_ready low.
    xfer("bp", 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
    chk("bp_rdata", rd, 32'hDEAD_BEEF);

    // Reset during WAIT abandons the store.
    xfer("st30", 1'b1, 32'h30, 32'h5555_5555, 4'hF, 0, rd, er);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h9999_9999;
    req_wstrb = 4'hF;
    @(posedge clk);  // accept edge
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_in_wait_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("wr_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("wr_rst_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    xfer("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er);
    chk("ld30_rdata", rd, 32'h5555_5555);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's data-memory port. The core's memory stage issues load/store requests over a valid/ready request channel. This block accepts one request at a time and performs it on an internal word-addressed array after a programmable number of wait states. It then returns a held response on a valid/ready response channel. It models a slow data memory so the core's stall and handshake logic can be exercised.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array; must be a power of two ≥ 4.
- LATENCY, 2: wait states between request accept and memory access; legal range 0..15.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_wstrb  in  4  byte enables for stores; bit i enables byte lane i, i.e. bits [8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  request was misaligned or out of range

## Operation
- Reset behaviour:
  - Reset is asynchronous and active-low.
  - While rst = 0: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP. Exactly one request is outstanding at most.
- IDLE:
  - req_ready = 1 (registered; it is 0 during reset and goes high on the first edge after rst deasserts).
  - On a clock edge with req_valid & req_ready: capture we, addr, wdata and wstrb; load counter = LATENCY; go to WAIT.
- WAIT:
  - req_ready = 0.
  - If counter ≠ 0: decrement the counter.
  - If counter = 0: perform the access, register the response, go to RESP.
- Access rules, applied on the WAIT→RESP edge:
  - Error case: addr[1:0] ≠ 0 or addr[31:2] ≥ DEPTH_WORDS. No array change; rsp_err = 1; rsp_rdata = 0.
  - Load: rsp_rdata = mem[addr[31:2]]; rsp_err = 0.
  - Store: for each i, byte lane i is written iff wstrb[i]. rsp_rdata = 0; rsp_err = 0. wstrb = 4'b0000 is legal, leaves the array unchanged, and still produces a response.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable until the handshake.
  - On an edge with rsp_ready = 1: go to IDLE and clear rsp_valid, rsp_rdata and rsp_err to 0.
  - If rsp_ready stays low, the block remains in RESP indefinitely.
- req_valid is ignored outside IDLE. The request fields are sampled only on the accept edge, so later changes to the inputs have no effect.
- Reset during WAIT: the request is abandoned and no write occurs.
- Reset during RESP: the response is dropped; any store already committed stays committed.
- Outputs are driven only from registers; there is no combinational path from any input to any output.

## Timing
- Accept edge E0 is an edge with req_valid & req_ready high.
- Latency: rsp_valid rises after edge E0 + LATENCY + 1.
  - LATENCY = 0: visible in the cycle after E1.
  - LATENCY = 2: visible after E3.
- The store is committed on the same edge that raises rsp_valid, so a load accepted later always sees it.
- Response handshake at edge Er: req_ready is high after Er, and the next accept is at Er+1 at the earliest.
- Minimum request-to-request period is LATENCY + 3 cycles when rsp_ready is held high.
- A rsp_ready pulse seen while the block is not in RESP has no effect.

## Test plan
- Reset: hold rst = 0 for 3 cycles with req_valid = 1 → all outputs 0 and no accept; first edge after release → req_ready = 1.
- Store then load, LATENCY = 2:
  - Store addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF → rsp_valid after E0+3, rsp_rdata = 0, rsp_err = 0.
  - Load 0x10 → rsp_rdata = 0xDEADBEEF.
- Byte strobes: store 0x11223344 to 0x20 with wstrb 4'b0101 over a word of 0xAAAAAAAA → a later load returns 0xAA22AA44.
- Errors:
  - Load 0x13 (misaligned) → rsp_err = 1, rsp_rdata = 0.
  - Store to byte address 4×DEPTH_WORDS → rsp_err = 1, and the word at address 0 is unchanged.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid rises → rsp_valid and rsp_rdata stay stable and req_ready stays 0; raising rsp_ready gives one handshake, then req_ready = 1 on the next cycle.
- Reset during WAIT: accept a store to 0x30, assert rst during WAIT, then release it and load 0x30 → the old value is returned.
